// File: rtl/rambus_pkg.sv
// rtl/rambus_pkg.sv - shared rambus widths and arbiter state encoding
package rambus_pkg;

  localparam int RAMBUS_ADR_W = 10;
  localparam int RAMBUS_DAT_W = 32;
  localparam int RAMBUS_SEL_W = 4;
  localparam int TOCNT_W      = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin picker, search starts after i_last
module rr_picker #(
  parameter int N  = 4,
  parameter int LW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [LW-1:0] i_last,
  output logic [N-1:0]  o_grant
);

  always_comb begin
    logic [LW-1:0] w_idx;
    logic          w_found;
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 1; i <= N; i++) begin
      w_idx = LW'((int'(i_last) + i) % N);
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_rambus_arbiter.sv
// rtl/wb_rambus_arbiter.sv - round-robin Wishbone arbiter onto the OpenRAM rambus port
// A granted transfer that stalls for TIMEOUT_CYCLES strobed cycles is aborted.
module wb_rambus_arbiter
  import rambus_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                              wb_clk_i,
  input  logic                              wb_rst_i,
  input  logic [NUM_MASTERS-1:0]            enable_i,
  input  logic [NUM_MASTERS-1:0]            m_cyc_i,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [RAMBUS_SEL_W*NUM_MASTERS-1:0] m_sel_i,
  input  logic [RAMBUS_ADR_W*NUM_MASTERS-1:0] m_adr_i,
  input  logic [RAMBUS_DAT_W*NUM_MASTERS-1:0] m_dat_i,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  output logic [RAMBUS_DAT_W-1:0]           m_dat_o,
  output logic                              s_cyc_o,
  output logic                              s_stb_o,
  output logic                              s_we_o,
  output logic [RAMBUS_SEL_W-1:0]           s_sel_o,
  output logic [RAMBUS_ADR_W-1:0]           s_adr_o,
  output logic [RAMBUS_DAT_W-1:0]           s_dat_o,
  input  logic                              s_ack_i,
  input  logic [RAMBUS_DAT_W-1:0]           s_dat_i,
  output logic [NUM_MASTERS-1:0]            grant_o,
  output logic [TOCNT_W-1:0]                timeout_cnt_o
);

  localparam int LW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  arb_state_e             r_state;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [LW-1:0]          r_last;
  logic [TOCNT_W-1:0]     r_wait;
  logic [TOCNT_W-1:0]     r_aborts;

  logic [NUM_MASTERS-1:0]  w_req;
  logic [NUM_MASTERS-1:0]  w_pick;
  logic [LW-1:0]           w_gidx;
  logic                    w_cyc;
  logic                    w_stb;
  logic                    w_we;
  logic                    w_en;
  logic [RAMBUS_SEL_W-1:0] w_sel;
  logic [RAMBUS_ADR_W-1:0] w_adr;
  logic [RAMBUS_DAT_W-1:0] w_dat;
  logic                    w_busy;
  logic                    w_stall;
  logic                    w_timeout;

  assign w_req = m_cyc_i & m_stb_i & enable_i;

  rr_picker #(
    .N  (NUM_MASTERS),
    .LW (LW)
  ) u_picker (
    .i_req   (w_req),
    .i_last  (r_last),
    .o_grant (w_pick)
  );

  // One-hot select of the granted master's signals and its index.
  always_comb begin
    w_gidx = '0;
    w_cyc  = 1'b0;
    w_stb  = 1'b0;
    w_we   = 1'b0;
    w_en   = 1'b0;
    w_sel  = '0;
    w_adr  = '0;
    w_dat  = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (r_grant[k]) begin
        w_gidx = LW'(k);
        w_cyc  = m_cyc_i[k];
        w_stb  = m_stb_i[k];
        w_we   = m_we_i[k];
        w_en   = enable_i[k];
        w_sel  = m_sel_i[k*RAMBUS_SEL_W +: RAMBUS_SEL_W];
        w_adr  = m_adr_i[k*RAMBUS_ADR_W +: RAMBUS_ADR_W];
        w_dat  = m_dat_i[k*RAMBUS_DAT_W +: RAMBUS_DAT_W];
      end
    end
  end

  assign w_busy    = (r_state == BUSY);
  assign w_stall   = w_busy && w_stb && !s_ack_i;
  assign w_timeout = w_stall && (r_wait == TOCNT_W'(TIMEOUT_CYCLES - 1));

  assign s_cyc_o       = w_busy && w_cyc;
  assign s_stb_o       = w_busy && w_stb;
  assign s_we_o        = w_busy && w_we;
  assign s_sel_o       = w_busy ? w_sel : '0;
  assign s_adr_o       = w_busy ? w_adr : '0;
  assign s_dat_o       = w_busy ? w_dat : '0;
  assign m_ack_o       = (w_busy && s_ack_i) ? r_grant : '0;
  assign m_err_o       = w_timeout ? r_grant : '0;
  assign m_dat_o       = s_dat_i;
  assign grant_o       = r_grant;
  assign timeout_cnt_o = r_aborts;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_last   <= LW'(NUM_MASTERS - 1);
      r_wait   <= '0;
      r_aborts <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (|w_req) begin
            r_grant <= w_pick;
            r_wait  <= '0;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          // An ack in the threshold cycle keeps w_timeout low, so the ack wins.
          if (w_timeout) begin
            r_state <= ABORT;
            r_wait  <= '0;
            if (r_aborts != '1) r_aborts <= r_aborts + 1'b1;
          end else if (!w_cyc || !w_en) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= w_gidx;
          end else if (s_ack_i) begin
            r_wait <= '0;
          end else if (w_stall) begin
            r_wait <= r_wait + 1'b1;
          end
        end
        ABORT: begin
          if (!w_cyc) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= w_gidx;
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_rambus_arbiter.sv
// tb/tb_wb_rambus_arbiter.sv - self-checking bench for wb_rambus_arbiter
module tb_wb_rambus_arbiter;

  localparam int NM = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NM-1:0] en  = '0;
  logic [NM-1:0] cyc = '0;
  logic [NM-1:0] stb = '0;
  logic [NM-1:0] we  = '0;
  logic [3:0]  b_sel [NM];
  logic [9:0]  b_adr [NM];
  logic [31:0] b_dat [NM];
  logic [4*NM-1:0]  p_sel;
  logic [10*NM-1:0] p_adr;
  logic [32*NM-1:0] p_dat;
  logic        s_ack  = 1'b0;
  logic [31:0] s_rdat = '0;

  logic [NM-1:0] m_ack_o, m_err_o, grant_o;
  logic [31:0]   m_dat_o, s_dat_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]    s_sel_o;
  logic [9:0]    s_adr_o;
  logic [7:0]    timeout_cnt_o;

  int n_chk = 0;
  int n_err = 0;

  for (genvar k = 0; k < NM; k++) begin : g_pack
    assign p_sel[k*4 +: 4]   = b_sel[k];
    assign p_adr[k*10 +: 10] = b_adr[k];
    assign p_dat[k*32 +: 32] = b_dat[k];
  end

  wb_rambus_arbiter #(.NUM_MASTERS(NM), .TIMEOUT_CYCLES(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .enable_i(en),
    .m_cyc_i(cyc), .m_stb_i(stb), .m_we_i(we),
    .m_sel_i(p_sel), .m_adr_i(p_adr), .m_dat_i(p_dat),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_ack_i(s_ack), .s_dat_i(s_rdat),
    .grant_o(grant_o), .timeout_cnt_o(timeout_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int oh2i(input logic [NM-1:0] v);
    oh2i = -1;
    for (int k = 0; k < NM; k++) if (v[k]) oh2i = k;
  endfunction

  // Reference model: who owns the bus, whether it was aborted, stalled strobes so far.
  int mdl_owner = -1;
  bit mdl_abort = 1'b0;
  int mdl_stall = 0;
  int mdl_tos   = 0;
  int mdl_last  = NM - 1;
  bit mdl_valid = 1'b0;

  always @(negedge clk) begin
    logic [NM-1:0] e_grant, e_ack, e_err;
    logic [6:0]    e_ctl;
    logic [9:0]    e_adr;
    logic [31:0]   e_dat;
    bit            busy, err_now;
    int            g;
    g       = mdl_owner;
    busy    = (g >= 0) && !mdl_abort;
    err_now = busy && stb[g] && !s_ack && (mdl_stall == TO - 1);
    if (mdl_valid) begin
      e_grant = '0; e_ack = '0; e_err = '0; e_ctl = '0; e_adr = '0; e_dat = '0;
      if (g >= 0) e_grant[g] = 1'b1;
      if (busy) begin
        e_ctl = {cyc[g], stb[g], we[g], b_sel[g]};
        e_adr = b_adr[g];
        e_dat = b_dat[g];
        if (s_ack) e_ack[g] = 1'b1;
        if (err_now) e_err[g] = 1'b1;
      end
      chk("grant", grant_o, e_grant);
      chk("m_ack", m_ack_o, e_ack);
      chk("m_err", m_err_o, e_err);
      chk("s_ctl", {s_cyc_o, s_stb_o, s_we_o, s_sel_o}, e_ctl);
      chk("s_adr", s_adr_o, e_adr);
      chk("s_dat", s_dat_o, e_dat);
      chk("m_dat", m_dat_o, s_rdat);
      chk("to_cnt", timeout_cnt_o, mdl_tos);
    end
    if (rst) begin
      mdl_owner = -1; mdl_abort = 1'b0; mdl_stall = 0; mdl_tos = 0;
      mdl_last = NM - 1; mdl_valid = 1'b1;
    end else if (mdl_valid) begin
      if (g < 0) begin
        for (int j = 1; j <= NM; j++) begin
          int c;
          c = (mdl_last + j) % NM;
          if (mdl_owner < 0 && cyc[c] && stb[c] && en[c]) mdl_owner = c;
        end
        mdl_stall = 0;
      end else if (!mdl_abort) begin
        if (err_now) begin
          mdl_abort = 1'b1;
          if (mdl_tos < 255) mdl_tos++;
        end else if (!cyc[g] || !en[g]) begin
          mdl_last = g; mdl_owner = -1;
        end else if (s_ack) mdl_stall = 0;
        else if (stb[g]) mdl_stall++;
      end else if (!cyc[g]) begin
        mdl_last = g; mdl_owner = -1; mdl_abort = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int left [NM];
  int acks [NM];
  int g_order[$];
  int g_gaps[$];
  bit gap = 1'b0;
  bit m1_granted;
  logic [NM-1:0] last_ack;

  // Reactive masters: each drops cyc after its last ack; the slave acks any strobe at once.
  task automatic serve(input int max_cyc);
    logic [NM-1:0] prev_g;
    int idle_run;
    prev_g = '0; idle_run = 0; last_ack = '0; m1_granted = 1'b0;
    g_order.delete(); g_gaps.delete();
    for (int k = 0; k < NM; k++) acks[k] = 0;
    for (int c = 0; c < max_cyc; c++) begin
      step();
      for (int k = 0; k < NM; k++) begin
        if (last_ack[k]) begin
          left[k]--;
          cyc[k] = (left[k] > 0);
          stb[k] = (left[k] > 0) && !gap;
        end else if (cyc[k]) stb[k] = 1'b1;
      end
      #1;
      s_ack = s_stb_o;
      #1;
      last_ack = m_ack_o;
      for (int k = 0; k < NM; k++) acks[k] += int'(m_ack_o[k]);
      if (grant_o[1]) m1_granted = 1'b1;
      if (grant_o == '0) idle_run++;
      else if (grant_o != prev_g) begin
        if (g_order.size() > 0) g_gaps.push_back(prev_g == '0 ? idle_run : 0);
        g_order.push_back(oh2i(grant_o));
        idle_run = 0;
      end
      prev_g = grant_o;
    end
    s_ack = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog at %0t: got timeout expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_err;
    int ack_pct;
    for (int k = 0; k < NM; k++) begin
      b_sel[k] = '0; b_adr[k] = '0; b_dat[k] = '0;
    end
    s_rdat = 32'h1234_5678;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_grant", grant_o, 4'b0000);
    chk("rst_tocnt", timeout_cnt_o, 8'd0);
    chk("rst_scyc", s_cyc_o, 1'b0);

    // Master 1 writes 0xDEADBEEF to 0x005, slave acks one cycle after stb rises
    en = 4'hF;
    step();
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1;
    b_sel[1] = 4'hF; b_adr[1] = 10'h005; b_dat[1] = 32'hDEAD_BEEF;
    #1 chk("w_pre_stb", s_stb_o, 1'b0);
    step();
    chk("w_grant", grant_o, 4'b0010);
    chk("w_stb", s_stb_o, 1'b1);
    chk("w_adr", s_adr_o, 10'h005);
    chk("w_dat", s_dat_o, 32'hDEAD_BEEF);
    chk("w_noack", m_ack_o, 4'b0000);
    step();
    s_ack = 1'b1;
    #1 chk("w_ack", m_ack_o, 4'b0010);
    step();
    s_ack = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
    #1 chk("w_hold", grant_o, 4'b0010);
    step();
    chk("w_release", grant_o, 4'b0000);

    // All four request out of reset
    rst = 1'b1; step(); rst = 1'b0;
    for (int k = 0; k < NM; k++) left[k] = 1;
    gap = 1'b0; cyc = 4'hF; stb = 4'hF;
    serve(24);
    chk("rr_count", g_order.size(), 4);
    for (int i = 0; i < g_order.size() && i < 4; i++) chk("rr_order", g_order[i], i);
    for (int i = 0; i < g_gaps.size(); i++) chk("rr_gap", g_gaps[i], 1);

    // Timeout: master 2, slave never acks
    step();
    cyc[2] = 1'b1; stb[2] = 1'b1; s_ack = 1'b0;
    first_err = 0;
    for (int i = 1; i <= TO; i++) begin
      step();
      if (m_err_o != '0 && first_err == 0) first_err = i;
    end
    chk("to_err_cycle", first_err, TO);
    chk("to_err_bit", m_err_o, 4'b0100);
    step();
    chk("to_scyc", s_cyc_o, 1'b0);
    chk("to_err_pulse", m_err_o, 4'b0000);
    chk("to_count", timeout_cnt_o, 8'd1);
    step(); step();
    chk("to_abort_hold", grant_o, 4'b0100);
    cyc[2] = 1'b0; stb[2] = 1'b0;
    step();
    chk("to_release", grant_o, 4'b0000);

    // Master 1 disabled but requesting continuously
    en = 4'b1101;
    left[0] = 1; left[1] = 1000; left[2] = 1; left[3] = 1;
    cyc = 4'hF; stb = 4'hF;
    serve(24);
    chk("en_m1_never", m1_granted, 1'b0);
    chk("en_ack0", acks[0], 1);
    chk("en_ack2", acks[2], 1);
    chk("en_ack3", acks[3], 1);
    cyc = '0; stb = '0; en = 4'hF;
    step(); step();

    // Reset while master 3 is busy
    cyc[3] = 1'b1; stb[3] = 1'b1;
    step();
    chk("rb_grant3", grant_o, 4'b1000);
    rst = 1'b1;
    step();
    rst = 1'b0; s_ack = 1'b1; cyc[0] = 1'b1; stb[0] = 1'b1;
    #1;
    chk("rb_scyc", s_cyc_o, 1'b0);
    chk("rb_grant", grant_o, 4'b0000);
    chk("rb_ack", m_ack_o, 4'b0000);
    chk("rb_err", m_err_o, 4'b0000);
    step();
    chk("rb_first0", grant_o, 4'b0001);
    step();
    s_ack = 1'b0; cyc = '0; stb = '0;
    step(); step();

    // Master 0 bursts 3 strobes while master 1 waits
    rst = 1'b1; step(); rst = 1'b0;
    left[0] = 3; left[1] = 1; left[2] = 0; left[3] = 0;
    gap = 1'b1; cyc = 4'b0011; stb = 4'b0011;
    serve(24);
    gap = 1'b0;
    chk("bu_count", g_order.size(), 2);
    if (g_order.size() >= 2) begin
      chk("bu_first", g_order[0], 0);
      chk("bu_second", g_order[1], 1);
    end
    chk("bu_ack0", acks[0], 3);
    chk("bu_ack1", acks[1], 1);
    step();

    // Randomized phases checked by the model
    for (int ph = 0; ph < 12; ph++) begin
      en = 4'($urandom_range(1, 15));
      case (ph % 3)
        0:       ack_pct = 0;
        1:       ack_pct = 30;
        default: ack_pct = 70;
      endcase
      for (int c = 0; c < 120; c++) begin
        step();
        rst = ($urandom_range(0, 299) == 0);
        for (int k = 0; k < NM; k++) begin
          cyc[k]   = cyc[k] ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
          stb[k]   = cyc[k] && ($urandom_range(0, 3) != 0);
          we[k]    = 1'($urandom_range(0, 1));
          b_sel[k] = 4'($urandom);
          b_adr[k] = 10'($urandom);
          b_dat[k] = $urandom;
        end
        s_ack  = ($urandom_range(0, 99) < ack_pct);
        s_rdat = $urandom;
      end
      step();
      rst = 1'b0; cyc = '0; stb = '0; s_ack = 1'b0;
      repeat (3) step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
